multicycle_control_unit: RTL
============================

// Module: multicycle_control_unit
// PURPOSE
//  Main-FSM controller for the multicycle ARM datapath (shared instr/data memory, one ALU reused for PC+4).
//  Sequences FETCH/DECODE/EXECUTE/MEM/WB steps, decodes Op/Funct and owns the NZCV flag register.
//  Applies condition-code gating to every architectural write. Sits between the instruction register and the datapath muxes.
// PARAMETERS
//  FLAGS_RST  4'b0000  reset value of internal {N,Z,C,V} flag register
// PORTS
//  clk         in   1  single clock, rising edge
//  rst         in   1  asynchronous, active-low reset (rst==0 resets)
//  Cond        in   4  Instr[31:28], held stable by IR after FETCH
//  ALUFlags    in   4  {N,Z,C,V} from ALU, valid in EXECUTER/EXECUTEI
//  Op          in   2  Instr[27:26]
//  Funct       in   6  Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S (L for memory)
//  Rd          in   4  Instr[15:12]
//  PCWrite     out  1  PC load enable
//  IRWrite     out  1  instruction register load enable
//  RegWrite    out  1  register file write enable
//  MemWrite    out  1  memory write enable
//  AdrSrc      out  1  0=PC, 1=ALUOut as memory address
//  ALUSrcA     out  2  00=RD1 reg, 01=PC
//  ALUSrcB     out  2  00=RD2 reg, 01=ExtImm, 10=const 4
//  ResultSrc   out  2  00=ALUOut, 01=Data reg, 10=ALUResult
//  ImmSrc      out  2  =Op (combinational)
//  RegSrc      out  2  [0]=(Op==10), [1]=(Op==01) (combinational)
//  ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
// BEHAVIOUR
//  States/outputs (unlisted enables=0, unlisted selects=00):
//   FETCH: IRWrite=1, NextPC=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALU ADD -> DECODE
//   DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10 -> Op 01:MEMADR; 10:BRANCH; 00&I:EXECUTEI; 00&~I:EXECUTER; 11:UNKNOWN
//   MEMADR: ALUSrcB=01, ADD -> MEMREAD if Funct[0], else MEMWRITE
//   MEMREAD: AdrSrc=1 -> MEMWB.  MEMWB: ResultSrc=01, RegW=1 -> FETCH
//   MEMWRITE: AdrSrc=1, MemW=1 -> FETCH
//   EXECUTER: ALUSrcB=00, ALU per cmd -> ALUWB.  EXECUTEI: ALUSrcB=01, ALU per cmd -> ALUWB
//   ALUWB: ResultSrc=00, RegW=1 unless NoWrite -> FETCH
//   BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1, ADD -> FETCH.  UNKNOWN: no enables -> FETCH
//  Cmd decode: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB, NoWrite=1); other cmd -> ADD, NoWrite=1
//  FlagW: S=1 -> NZ update; CV also updated for ADD/SUB/CMP only; S=0 -> none
//  CondEx (comb. from Cond + flag reg): EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V,
//   HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V), AL 1, 1111 -> 0
//  Gating: RegWrite=RegW&CondEx; MemWrite=MemW&CondEx; PCWrite=NextPC|((Branch|PCS)&CondEx)
//   PCS=RegW&(Rd==15) in ALUWB/MEMWB; FETCH's NextPC is never gated
//  Flags reg: on the clk edge leaving EXECUTER/EXECUTEI, update fields selected by FlagW if CondEx
//   CondEx uses the pre-update flags
//  Latency: branch 3 cycles, data-proc/STR 4, LDR 5, UNKNOWN 3; an instr's 1st FETCH follows prev instr's last state
//  Reset (rst==0, async): state=FETCH, flags=FLAGS_RST; while low, PCWrite/IRWrite/RegWrite/MemWrite=0
//   and selects take FETCH values; first FETCH executes on first edge after rst rises; mid-instr reset aborts silently
// TESTING
//  1 rst low mid-MEMWRITE -> MemWrite drops to 0 immediately; after release FETCH with IRWrite=1, flags=0000
//  2 ADDS R1 (Op=00,Funct=101001,Cond=1110), ALUFlags=0110 -> FETCH,DECODE,EXECUTEI,ALUWB; RegWrite=1 in ALUWB; flags=0110
//  3 CMP (Funct=010101) then BEQ, ALUFlags Z=1 -> CMP RegWrite=0 in ALUWB; BEQ PCWrite=1 in BRANCH
//  4 LDR (Op=01,Funct[0]=1,Cond=0001) with Z=1 -> 5 states visited, RegWrite=0 in MEMWB; with Z=0 RegWrite=1
//  5 STR Cond=1110 -> MEMADR ALUSrcB=01, MEMWRITE AdrSrc=1 MemWrite=1; ADD Rd=15 -> PCWrite=1 and RegWrite=1 in ALUWB
//  6 Op=11 -> UNKNOWN then FETCH, no write enable asserted; Cond=1111 any instr -> no gated writes, flags unchanged

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Main-FSM controller for the multicycle ARM datapath: sequences the instruction steps,
// decodes Op/Funct, owns the NZCV flag register and condition-gates every architectural write.
module multicycle_control_unit #(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_UNKNOWN
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;

  logic [1:0] cmd_alu;
  logic       no_write, cv_upd, cond_ex, in_exec;
  logic       next_pc, ir_w, reg_w, mem_w, branch, adr_src;
  logic [1:0] src_a, src_b, res_src, alu_ctl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      flags_q <= FLAGS_RST;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR:  state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECR:   state_d = S_ALUWB;
      S_EXECI:   state_d = S_ALUWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // Unrecognised commands fall back to a harmless ADD that never writes a register.
  always_comb begin
    cmd_alu  = 2'b00;
    no_write = 1'b0;
    cv_upd   = 1'b0;
    case (Funct[4:1])
      4'b0100: begin cmd_alu = 2'b00; cv_upd = 1'b1; end
      4'b0010: begin cmd_alu = 2'b01; cv_upd = 1'b1; end
      4'b0000: cmd_alu = 2'b10;
      4'b1100: cmd_alu = 2'b11;
      4'b1010: begin cmd_alu = 2'b01; no_write = 1'b1; cv_upd = 1'b1; end
      default: no_write = 1'b1;
    endcase
  end

  always_comb begin
    cond_ex = 1'b0;
    case (Cond)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = ~flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = ~flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = ~flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = ~flags_q[0];
      4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
      4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign in_exec = (state_q == S_EXECR) || (state_q == S_EXECI);

  // Flags commit on the edge leaving EXECUTE, gated by the condition seen before the update.
  always_comb begin
    flags_d = flags_q;
    if (in_exec && cond_ex && Funct[0]) begin
      flags_d[3:2] = ALUFlags[3:2];
      if (cv_upd) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_comb begin
    next_pc = 1'b0;
    ir_w    = 1'b0;
    reg_w   = 1'b0;
    mem_w   = 1'b0;
    branch  = 1'b0;
    adr_src = 1'b0;
    src_a   = 2'b00;
    src_b   = 2'b00;
    res_src = 2'b00;
    alu_ctl = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_w = 1'b1; next_pc = 1'b1;
        src_a = 2'b01; src_b = 2'b10; res_src = 2'b10;
      end
      S_DECODE: begin
        src_a = 2'b01; src_b = 2'b10; res_src = 2'b10;
      end
      S_MEMADR:   src_b = 2'b01;
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB:    begin res_src = 2'b01; reg_w = 1'b1; end
      S_MEMWRITE: begin adr_src = 1'b1; mem_w = 1'b1; end
      S_EXECR:    alu_ctl = cmd_alu;
      S_EXECI:    begin src_b = 2'b01; alu_ctl = cmd_alu; end
      S_ALUWB:    reg_w = ~no_write;
      S_BRANCH:   begin src_b = 2'b01; res_src = 2'b10; branch = 1'b1; end
      default:    ;
    endcase
  end

  // Enables are held low combinationally while reset is asserted.
  assign PCWrite    = rst & (next_pc | ((branch | (reg_w & (Rd == 4'd15))) & cond_ex));
  assign IRWrite    = rst & ir_w;
  assign RegWrite   = rst & reg_w & cond_ex;
  assign MemWrite   = rst & mem_w & cond_ex;
  assign AdrSrc     = adr_src;
  assign ALUSrcA    = src_a;
  assign ALUSrcB    = src_b;
  assign ResultSrc  = res_src;
  assign ALUControl = alu_ctl;
  assign ImmSrc     = Op;
  assign RegSrc     = {(Op == 2'b01), (Op == 2'b10)};

endmodule
